// File: rtl/cache_fill_if.sv
// Handshake bundle between the L1 cache / main memory side and the cache fill controller.
interface cache_fill_if #(
  parameter int WORD_IDX_W = 3,
  parameter int ADDR_W     = 16
);
  logic                  miss_detected;
  logic [ADDR_W-1:0]     miss_address;
  logic                  mem_data_valid;
  logic [15:0]           mem_data;
  logic                  fsm_busy;
  logic                  mem_req;
  logic [ADDR_W-1:0]     mem_address;
  logic                  write_data_array;
  logic                  write_tag_array;
  logic [WORD_IDX_W-1:0] fill_word;
  logic [15:0]           fill_data;

  modport master (
    output miss_detected, miss_address, mem_data_valid, mem_data,
    input  fsm_busy, mem_req, mem_address, write_data_array, write_tag_array,
           fill_word, fill_data
  );

  modport slave (
    input  miss_detected, miss_address, mem_data_valid, mem_data,
    output fsm_busy, mem_req, mem_address, write_data_array, write_tag_array,
           fill_word, fill_data
  );
endinterface

// File: rtl/cache_fill_fsm.sv
// Cache miss fill controller: issues one read per block word and writes data/tag arrays.
// Optional macro CRITICAL_WORD_FIRST_EN starts the fill at the missing word and wraps.
module cache_fill_fsm #(
  parameter int WORD_IDX_W = 3,
  parameter int ADDR_W     = 16
) (
  input logic         clk,
  input logic         rst,
  cache_fill_if.slave bus
);

  localparam int CNT_W = WORD_IDX_W + 1;
  localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'((1 << WORD_IDX_W) - 1);
  localparam logic [ADDR_W-1:0] BLK_MASK  = ~(ADDR_W'((1 << (WORD_IDX_W + 1)) - 1));
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1'b1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_t;

  state_t                state_r, state_nxt_s;
  logic [CNT_W-1:0]      issue_cnt_r, issue_cnt_nxt_s;
  logic [CNT_W-1:0]      recv_cnt_r, recv_cnt_nxt_s;
  logic [ADDR_W-1:0]     base_r, base_nxt_s;
  logic [WORD_IDX_W-1:0] start_r, start_nxt_s;
  logic [WORD_IDX_W-1:0] miss_start_s;

  logic                  busy_s, req_s, wr_data_s, wr_tag_s;
  logic [WORD_IDX_W-1:0] issue_idx_s, issue_word_s;

`ifdef CRITICAL_WORD_FIRST_EN
  assign miss_start_s = bus.miss_address[WORD_IDX_W:1];
`else
  assign miss_start_s = {WORD_IDX_W{1'b0}};
`endif

  // State, counter and latched-block registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      issue_cnt_r <= {CNT_W{1'b0}};
      recv_cnt_r  <= {CNT_W{1'b0}};
      base_r      <= {ADDR_W{1'b0}};
      start_r     <= {WORD_IDX_W{1'b0}};
    end else begin
      state_r     <= state_nxt_s;
      issue_cnt_r <= issue_cnt_nxt_s;
      recv_cnt_r  <= recv_cnt_nxt_s;
      base_r      <= base_nxt_s;
      start_r     <= start_nxt_s;
    end
  end

  // Next-state and strobe decode
  always_comb begin
    state_nxt_s     = state_r;
    issue_cnt_nxt_s = issue_cnt_r;
    recv_cnt_nxt_s  = recv_cnt_r;
    base_nxt_s      = base_r;
    start_nxt_s     = start_r;
    busy_s          = 1'b0;
    req_s           = 1'b0;
    wr_data_s       = 1'b0;
    wr_tag_s        = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.miss_detected) begin
          base_nxt_s      = bus.miss_address & BLK_MASK;
          start_nxt_s     = miss_start_s;
          issue_cnt_nxt_s = {CNT_W{1'b0}};
          recv_cnt_nxt_s  = {CNT_W{1'b0}};
          state_nxt_s     = FILL;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      FILL: begin
        busy_s = 1'b1;
        // MSB of the issue counter marks that every word has been requested
        if (!issue_cnt_r[WORD_IDX_W]) begin
          req_s           = 1'b1;
          issue_cnt_nxt_s = issue_cnt_r + CNT_ONE;
        end else begin
          req_s = 1'b0;
        end
        if (bus.mem_data_valid) begin
          wr_data_s      = 1'b1;
          recv_cnt_nxt_s = recv_cnt_r + CNT_ONE;
          if (recv_cnt_r == LAST_CNT) begin
            wr_tag_s    = 1'b1;
            state_nxt_s = IDLE;
          end else begin
            state_nxt_s = FILL;
          end
        end else begin
          state_nxt_s = FILL;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Once all requests are out the address holds at the last issued word
  assign issue_idx_s  = issue_cnt_r[WORD_IDX_W] ? {WORD_IDX_W{1'b1}}
                                                : issue_cnt_r[WORD_IDX_W-1:0];
  assign issue_word_s = start_r + issue_idx_s;

  assign bus.fsm_busy         = busy_s;
  assign bus.mem_req          = req_s;
  assign bus.mem_address      = base_r + {{(ADDR_W-WORD_IDX_W-1){1'b0}}, issue_word_s, 1'b0};
  assign bus.write_data_array = wr_data_s;
  assign bus.write_tag_array  = wr_tag_s;
  assign bus.fill_word        = start_r + recv_cnt_r[WORD_IDX_W-1:0];
  assign bus.fill_data        = bus.mem_data;

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Scoreboard bench for cache_fill_fsm with a latency/gap-configurable memory model.
module tb_cache_fill_fsm;

  localparam int WIW = 3;
  localparam int AW  = 16;
  localparam int NW  = 1 << WIW;
  localparam logic [AW-1:0] BLK_MASK = 16'hFFF0;

  typedef struct {
    logic [AW-1:0] addr;
    int            due;
  } mreq_t;

  typedef struct {
    logic [WIW-1:0] word;
    logic [15:0]    data;
    logic           last;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cache_fill_if #(.WORD_IDX_W(WIW), .ADDR_W(AW)) bus ();

  cache_fill_fsm #(.WORD_IDX_W(WIW), .ADDR_W(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  logic [AW-1:0] exp_req_q[$];
  wr_t           exp_wr_q[$];
  mreq_t         mem_q[$];

  int n_checks  = 0;
  int n_fail    = 0;
  int cyc       = 0;
  int wr_count  = 0;
  int tag_count = 0;
  int mem_lat   = 4;
  int next_ok   = 0;
  bit irregular = 1'b0;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: returns data = request address, mem_lat cycles after the request
  initial begin
    bus.mem_data_valid = 1'b0;
    bus.mem_data       = 16'h0000;
    forever begin
      @(posedge clk);
      #2;
      if (rst) begin
        mem_q.delete();
        bus.mem_data_valid = 1'b0;
        bus.mem_data       = 16'h0000;
      end else if (mem_q.size() > 0 && mem_q[0].due <= cyc && cyc >= next_ok) begin
        mreq_t m;
        m = mem_q.pop_front();
        bus.mem_data_valid = 1'b1;
        bus.mem_data       = m.addr;
        next_ok = irregular ? cyc + int'($urandom_range(2, 4)) : 0;
      end else begin
        bus.mem_data_valid = 1'b0;
        bus.mem_data       = 16'h0000;
      end
    end
  end

  // Scoreboard: compare every request and array write against the queued expectation
  always @(negedge clk) begin
    if (bus.mem_req) begin
      if (exp_req_q.size() == 0) begin
        check_value("unexpected_req", bus.mem_req, 1'b0);
      end else begin
        logic [AW-1:0] ea;
        ea = exp_req_q.pop_front();
        check_value("mem_address", bus.mem_address, ea);
      end
      mem_q.push_back('{bus.mem_address, cyc + mem_lat});
    end
    if (bus.write_tag_array) tag_count++;
    if (bus.write_data_array) begin
      wr_count++;
      if (exp_wr_q.size() == 0) begin
        check_value("unexpected_write", bus.write_data_array, 1'b0);
      end else begin
        wr_t ew;
        ew = exp_wr_q.pop_front();
        check_value("fill_word", bus.fill_word, ew.word);
        check_value("fill_data", bus.fill_data, ew.data);
        check_value("tag_with_word", bus.write_tag_array, ew.last);
      end
    end else if (bus.write_tag_array) begin
      check_value("stray_tag", bus.write_tag_array, 1'b0);
    end
  end

  task automatic start_fill(input logic [AW-1:0] a);
    logic [AW-1:0]  base;
    logic [WIW-1:0] st;
    logic [WIW-1:0] w;
    logic [AW-1:0]  ad;
    base = a & BLK_MASK;
`ifdef CRITICAL_WORD_FIRST_EN
    st = a[WIW:1];
`else
    st = 3'd0;
`endif
    for (int k = 0; k < NW; k++) begin
      w  = st + WIW'(k);
      ad = base + {12'h000, w, 1'b0};
      exp_req_q.push_back(ad);
      exp_wr_q.push_back('{w, ad, (k == NW - 1)});
    end
    @(posedge clk);
    #1;
    bus.miss_detected = 1'b1;
    bus.miss_address  = a;
    @(posedge clk);
    #1;
    bus.miss_detected = 1'b0;
    bus.miss_address  = 16'h0000;
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (!bus.fsm_busy && exp_wr_q.size() == 0 && exp_req_q.size() == 0) done = 1'b1;
    end
    check_value("fill_done", done, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int wr0;
    int tag0;
    bit got3;
    bus.miss_detected = 1'b0;
    bus.miss_address  = 16'h0000;

    // Reset
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_value("rst_busy", bus.fsm_busy, 1'b0);
    check_value("rst_req", bus.mem_req, 1'b0);
    check_value("rst_addr", bus.mem_address, 16'h0000);
    check_value("rst_wda", bus.write_data_array, 1'b0);
    check_value("rst_wta", bus.write_tag_array, 1'b0);
    check_value("rst_word", bus.fill_word, 3'd0);

    // Basic fill with cycle-exact busy/req/tag timing
    start_fill(16'h1236);
    for (int i = 1; i <= 14; i++) begin
      @(negedge clk);
      check_value($sformatf("busy_c%0d", i), bus.fsm_busy, (i <= 12));
      check_value($sformatf("req_c%0d", i), bus.mem_req, (i <= 8));
      check_value($sformatf("tag_c%0d", i), bus.write_tag_array, (i == 12));
    end
    wait_idle();

    // Miss raised during a fill must not start anything
    start_fill(16'h1236);
    repeat (2) @(posedge clk);
    #1;
    bus.miss_detected = 1'b1;
    bus.miss_address  = 16'h4000;
    repeat (4) @(posedge clk);
    #1;
    bus.miss_detected = 1'b0;
    bus.miss_address  = 16'h0000;
    wait_idle();

    // Irregular memory: 1-3 idle cycles between returned words
    irregular = 1'b1;
    wr0  = wr_count;
    tag0 = tag_count;
    start_fill(16'h5A5A);
    wait_idle();
    irregular = 1'b0;
    check_value("irr_writes", wr_count - wr0, NW);
    check_value("irr_tags", tag_count - tag0, 1);

    // Reset in the middle of a fill
    wr0  = wr_count;
    tag0 = tag_count;
    start_fill(16'h1236);
    got3 = 1'b0;
    for (int i = 0; i < 50 && !got3; i++) begin
      @(negedge clk);
      if (wr_count - wr0 >= 3) got3 = 1'b1;
    end
    check_value("three_words", got3, 1'b1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    exp_req_q.delete();
    exp_wr_q.delete();
    mem_q.delete();
    @(negedge clk);
    check_value("midrst_busy", bus.fsm_busy, 1'b0);
    check_value("midrst_wta", bus.write_tag_array, 1'b0);
    check_value("midrst_tags", tag_count - tag0, 0);

    // Clean restart after the aborted fill
    wr0 = wr_count;
    start_fill(16'h2000);
    wait_idle();
    check_value("restart_writes", wr_count - wr0, NW);
    check_value("req_q_left", exp_req_q.size(), 0);
    check_value("wr_q_left", exp_wr_q.size(), 0);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cache_fill_fsm.md
Name: cache_fill_fsm

Overview:
- Miss-handling controller between an L1 cache (instruction or data side) and the multi-cycle, pipelined main memory that feeds the IF and MEM stages.
- On a cache miss it latches the block address and issues one read request per word of the block.
- It writes each returned word into the cache data array, then writes the tag array when the last word arrives.
- It holds busy high for the whole fill so the pipeline stalls.

Parameters:
- WORD_IDX_W, 3, word-index width; block holds 2**WORD_IDX_W 16-bit words (default 8 words = 16 bytes).
- ADDR_W, 16, byte-address width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- miss_detected  in  1  cache miss; sampled only in IDLE.
- miss_address  in  ADDR_W  byte address of the missing access.
- mem_data_valid  in  1  memory returns one word this cycle, in request order.
- mem_data  in  16  returned word.
- fsm_busy  out  1  fill in progress; pipeline stall request.
- mem_req  out  1  read request to memory this cycle.
- mem_address  out  ADDR_W  word-aligned request address.
- write_data_array  out  1  write fill_data at fill_word of the selected line.
- write_tag_array  out  1  write tag/valid for the latched block.
- fill_word  out  WORD_IDX_W  word index being written.
- fill_data  out  16  data for the data array (equals mem_data).

Behaviour:
- Reset:
  - state=IDLE; issue and receive counters = 0; base = 0.
  - All outputs 0, including mem_address.
  - rst mid-fill aborts immediately: no tag write, and partially written words remain invalid because the tag is never written.
- States: IDLE, FILL.
- IDLE:
  - fsm_busy=0, mem_req=0, all write strobes 0.
  - mem_data_valid is ignored.
  - If miss_detected at the clock edge: base <= miss_address with low WORD_IDX_W+1 bits cleared; counters <= 0; go to FILL.
- FILL:
  - fsm_busy=1.
  - Issue side: while issue_cnt < 2**WORD_IDX_W, mem_req=1 and mem_address = base + 2*issue_cnt. issue_cnt increments every cycle, so all requests go out on consecutive cycles, starting the first cycle of FILL. After that, mem_req=0 and mem_address holds its last value.
  - Receive side: each cycle mem_data_valid=1 gives write_data_array=1, fill_word=recv_cnt, fill_data=mem_data, then recv_cnt increments.
  - Gaps between valids are legal, and the block is independent of memory latency.
  - Completion: when mem_data_valid=1 and recv_cnt = 2**WORD_IDX_W-1, write_tag_array=1 in the same cycle as the last data write, and the next state is IDLE. fsm_busy drops the following cycle.
- miss_detected and miss_address changes during FILL are ignored; base is frozen.
- A miss held high through completion is re-sampled in the first IDLE cycle and starts a new fill. The cache must drop the miss once its tag is valid.
- Only one fill is outstanding at a time; arbitration between I-cache and D-cache is done outside this block.
- All outputs come from registered state and counters plus mem_data_valid/mem_data; there is no combinational path from miss_detected to any output.
- Arithmetic: address adds are modulo 2**ADDR_W. Counters are WORD_IDX_W+1 bits wide so the full-issue condition is detectable.

Optional Feature:
CRITICAL_WORD_FIRST_EN:
- Defined:
  - Issue and receive order start at word index miss_address[WORD_IDX_W:1] and wrap modulo 2**WORD_IDX_W.
  - mem_address = base + 2*((start+issue_cnt) mod 2**WORD_IDX_W).
  - fill_word = (start+recv_cnt) mod 2**WORD_IDX_W.
  - The tag write still coincides with the final (8th) returned word.
- Undefined: start = 0 (sequential order from word 0).

Test Plan:
- Reset test: assert rst for 2 cycles, then release with miss_detected=0 -> all outputs 0, fsm_busy=0.
- Basic fill:
  - Stimulus: miss_detected at edge T with miss_address 0x1236; memory model returns data 4 cycles after each request, with data = address.
  - mem_req is high on cycles T+1..T+8 with mem_address 0x1230, 0x1232, ..., 0x123E.
  - write_data_array pulses with fill_word 0..7 and fill_data 0x1230..0x123E.
  - write_tag_array fires with the 8th word at T+12; fsm_busy is high for cycles T+1..T+12 only.
- Ignored miss: during a fill of 0x1236, assert miss_detected with 0x4000 -> no extra mem_req; all addresses stay within 0x1230..0x123E.
- Irregular memory: memory returns valids with 1-3 idle cycles between them -> exactly 8 data writes with fill_word 0..7 in order; a single tag write with the last word.
- Reset mid-fill:
  - After 3 words are written, pulse rst -> next cycle fsm_busy=0, no tag write.
  - A subsequent miss at 0x2000 restarts cleanly: addresses 0x2000..0x200E, fill_word 0..7.
- CRITICAL_WORD_FIRST_EN defined, miss at 0x1236 -> addresses 0x1236, 0x1238, 0x123A, 0x123C, 0x123E, 0x1230, 0x1232, 0x1234; fill_word 3, 4, 5, 6, 7, 0, 1, 2; tag write with fill_word 2.
